// File: rtl/multi_template_classifier_if.sv
// Frame/sample input bus and classification result bus of the N-way template classifier.
interface multi_template_classifier_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned NT = 4,
  parameter int unsigned CW = 12
);
  localparam int unsigned TW = $clog2(NT);

  logic              frame_start;
  logic              sample_valid;
  logic              frame_last;
  logic [DW-1:0]     wave_in;
  logic [DW-1:0]     dwave_in;
  logic [NT*DW-1:0]  tmpl_in;
  logic [NT*DW-1:0]  dtmpl_in;
  logic              busy;
  logic              result_valid;
  logic [TW-1:0]     result_type;
  logic [CW:0]       result_score;
  logic [CW:0]       result_margin;

  modport master (
    output frame_start, sample_valid, frame_last, wave_in, dwave_in, tmpl_in, dtmpl_in,
    input  busy, result_valid, result_type, result_score, result_margin
  );

  modport slave (
    input  frame_start, sample_valid, frame_last, wave_in, dwave_in, tmpl_in, dtmpl_in,
    output busy, result_valid, result_type, result_score, result_margin
  );
endinterface

// File: rtl/multi_template_classifier.sv
// N-way waveform classifier: saturating raw/derivative hit-miss scores per class, sequential argmax at frame end.
// Optional macro CLASSIFIER_MARGIN_EN adds second-best tracking and a best-minus-second margin output.
module multi_template_classifier #(
  parameter int unsigned DW         = 8,
  parameter int unsigned NT         = 4,
  parameter int unsigned CW         = 12,
  parameter int unsigned THR0       = 10,
  parameter int unsigned THR1       = 2,
  parameter int unsigned HIT_INC    = 1,
  parameter int unsigned MISS_DEC   = 2,
  parameter int unsigned SCORE_INIT = 2048
) (
  input logic                          clk,
  input logic                          rst_n,
  multi_template_classifier_if.slave   bus
);
  localparam int unsigned IW = $clog2(NT);
  localparam int unsigned SW = CW + 1;
  localparam logic [CW-1:0] SMAX  = '1;
  localparam logic [CW-1:0] SINIT = CW'(SCORE_INIT);

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] raw_q [NT];
  logic [CW-1:0] der_q [NT];
  logic [IW-1:0] idx;
  logic [IW-1:0] best_idx;
  logic [SW-1:0] best;

  // True magnitude of a - b, one bit wider so small-vs-large never wraps into a false hit.
  function automatic logic [DW:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DW] ? (DW+1)'(-d) : d;
  endfunction

  function automatic logic [CW-1:0] score_step(input logic [CW-1:0] s, input logic hit);
    if (hit) return (s > SMAX - CW'(HIT_INC)) ? SMAX : s + CW'(HIT_INC);
    return (s < CW'(MISS_DEC)) ? '0 : s - CW'(MISS_DEC);
  endfunction

  logic [SW-1:0] total_c [NT];
  logic [SW-1:0] cur_c;
  logic          take_c;
  logic [SW-1:0] best_nx_c;
  logic [IW-1:0] best_idx_nx_c;

  always_comb begin
    for (int k = 0; k < NT; k++) total_c[k] = SW'(raw_q[k]) + SW'(der_q[k]);
  end

  // Strictly-greater update keeps the lowest index on ties; the first class seeds the scan.
  assign cur_c         = total_c[idx];
  assign take_c        = (idx == '0) || (cur_c > best);
  assign best_nx_c     = take_c ? cur_c : best;
  assign best_idx_nx_c = take_c ? idx : best_idx;

`ifdef CLASSIFIER_MARGIN_EN
  logic [SW-1:0] second;
  logic [SW-1:0] second_nx_c;

  always_comb begin
    second_nx_c = second;
    if (idx == '0)            second_nx_c = '0;
    else if (cur_c > best)    second_nx_c = best;
    else if (cur_c > second)  second_nx_c = cur_c;
  end
`else
  assign bus.result_margin = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= '0;
      best             <= '0;
      best_idx         <= '0;
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_type  <= '0;
      bus.result_score <= '0;
`ifdef CLASSIFIER_MARGIN_EN
      second            <= '0;
      bus.result_margin <= '0;
`endif
      for (int k = 0; k < NT; k++) begin
        raw_q[k] <= SINIT;
        der_q[k] <= SINIT;
      end
    end else begin
      bus.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            for (int k = 0; k < NT; k++) begin
              raw_q[k] <= SINIT;
              der_q[k] <= SINIT;
            end
            state    <= ACCUM;
            bus.busy <= 1'b1;
          end
        end
        ACCUM: begin
          if (bus.frame_start) begin
            for (int k = 0; k < NT; k++) begin
              raw_q[k] <= SINIT;
              der_q[k] <= SINIT;
            end
          end else if (bus.sample_valid) begin
            for (int k = 0; k < NT; k++) begin
              raw_q[k] <= score_step(raw_q[k],
                abs_diff(bus.wave_in, bus.tmpl_in[k*DW +: DW]) <= (DW+1)'(THR0));
              der_q[k] <= score_step(der_q[k],
                abs_diff(bus.dwave_in, bus.dtmpl_in[k*DW +: DW]) <= (DW+1)'(THR1));
            end
            if (bus.frame_last) begin
              state <= COMPARE;
              idx   <= '0;
            end
          end
        end
        COMPARE: begin
          best     <= best_nx_c;
          best_idx <= best_idx_nx_c;
          idx      <= idx + IW'(1);
`ifdef CLASSIFIER_MARGIN_EN
          second   <= second_nx_c;
`endif
          if (idx == IW'(NT - 1)) begin
            state            <= DONE;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b1;
            bus.result_type  <= best_idx_nx_c;
            bus.result_score <= best_nx_c;
`ifdef CLASSIFIER_MARGIN_EN
            bus.result_margin <= best_nx_c - second_nx_c;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_template_classifier.sv
// Self-checking bench: frame-level scoring model compared against the classifier every cycle.
module tb_multi_template_classifier;
  localparam int unsigned DW = 8;
  localparam int unsigned NT = 4;
  localparam int unsigned CW = 12;
  localparam int THR0 = 10;
  localparam int THR1 = 2;
  localparam int SMAX = 4095;
  localparam int SINIT = 2048;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  multi_template_classifier_if #(.DW(DW), .NT(NT), .CW(CW)) bus ();

  multi_template_classifier #(.DW(DW), .NT(NT), .CW(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int raw_m [NT];
  int der_m [NT];
  bit in_frame;
  int cycles_to_result;
  bit exp_valid;
  bit exp_busy;
  int exp_type, exp_score, exp_margin;
  int pend_type, pend_score, pend_margin;

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void reload();
    for (int k = 0; k < NT; k++) begin
      raw_m[k] = SINIT;
      der_m[k] = SINIT;
    end
  endfunction

  function automatic void score_frame();
    int tot [NT];
    int b, bi, sec;
    b = -1; bi = 0; sec = 0;
    for (int k = 0; k < NT; k++) begin
      tot[k] = raw_m[k] + der_m[k];
      if (tot[k] > b) begin b = tot[k]; bi = k; end
    end
    for (int k = 0; k < NT; k++) if (k != bi && tot[k] > sec) sec = tot[k];
    pend_type  = bi;
    pend_score = b;
`ifdef CLASSIFIER_MARGIN_EN
    pend_margin = b - sec;
`else
    pend_margin = 0;
`endif
  endfunction

  always @(posedge clk) begin
    bit was_done;
    if (!rst_n) begin
      in_frame = 0; cycles_to_result = 0; exp_valid = 0; exp_busy = 0;
      exp_type = 0; exp_score = 0; exp_margin = 0;
      reload();
    end else begin
      was_done  = exp_valid;
      exp_valid = 0;
      if (cycles_to_result > 0) begin
        cycles_to_result--;
        if (cycles_to_result == 0) begin
          exp_valid = 1; exp_type = pend_type; exp_score = pend_score; exp_margin = pend_margin;
        end
      end else if (in_frame) begin
        if (bus.frame_start) reload();
        else if (bus.sample_valid) begin
          for (int k = 0; k < NT; k++) begin
            int t, dt;
            t  = int'(bus.tmpl_in[k*DW +: DW]);
            dt = int'(bus.dtmpl_in[k*DW +: DW]);
            if (absi(int'(bus.wave_in) - t) <= THR0) raw_m[k] = (raw_m[k] + 1 > SMAX) ? SMAX : raw_m[k] + 1;
            else raw_m[k] = (raw_m[k] < 2) ? 0 : raw_m[k] - 2;
            if (absi(int'(bus.dwave_in) - dt) <= THR1) der_m[k] = (der_m[k] + 1 > SMAX) ? SMAX : der_m[k] + 1;
            else der_m[k] = (der_m[k] < 2) ? 0 : der_m[k] - 2;
          end
          if (bus.frame_last) begin
            in_frame = 0;
            score_frame();
            cycles_to_result = NT;
          end
        end
      end else if (!was_done && bus.frame_start) begin
        in_frame = 1;
        reload();
      end
      exp_busy = in_frame || (cycles_to_result > 0);
    end
  end

  // Single compare process, one step after each active edge.
  always @(posedge clk) begin
    #1;
    check("busy", 32'(bus.busy), 32'(exp_busy));
    check("result_valid", 32'(bus.result_valid), 32'(exp_valid));
    check("result_type", 32'(bus.result_type), 32'(exp_type));
    check("result_score", 32'(bus.result_score), 32'(exp_score));
    check("result_margin", 32'(bus.result_margin), 32'(exp_margin));
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] tv  [NT];
  logic [DW-1:0] dtv [NT];
  logic [DW-1:0] wv, dwv;

  task automatic put(input bit fs, input bit sv, input bit fl);
    @(negedge clk);
    bus.frame_start  = fs;
    bus.sample_valid = sv;
    bus.frame_last   = fl;
    bus.wave_in      = wv;
    bus.dwave_in     = dwv;
    for (int k = 0; k < NT; k++) begin
      bus.tmpl_in[k*DW +: DW]  = tv[k];
      bus.dtmpl_in[k*DW +: DW] = dtv[k];
    end
  endtask

  task automatic clear_inputs();
    bus.frame_start = 0; bus.sample_valid = 0; bus.frame_last = 0;
  endtask

  task automatic wait_result(input bit noise, output int lat);
    int n;
    bit seen;
    n = 0; seen = 0;
    @(posedge clk);
    #1 clear_inputs();
    while (!seen && n < 64) begin
      if (noise) begin
        bus.frame_start  = 1'($urandom_range(0, 1));
        bus.sample_valid = 1'($urandom_range(0, 1));
        bus.frame_last   = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      n++;
      if (bus.result_valid) seen = 1;
    end
    clear_inputs();
    if (!seen) check("result_timeout", 32'(seen), 32'd1);
    lat = n + 1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] near(input logic [DW-1:0] c, input int spread);
    int v;
    v = int'(c) + int'($urandom_range(0, 2 * spread)) - spread;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return DW'(v);
  endfunction

  // All classes except `win` miss by a wide margin; `win` matches exactly.
  task automatic set_match(input int win, input int i);
    wv  = DW'(20 + i % 30);
    dwv = DW'(200 - i % 30);
    for (int k = 0; k < NT; k++) begin
      tv[k]  = (k == win) ? wv  : DW'(int'(wv) + 100 + 20 * k);
      dtv[k] = (k == win) ? dwv : DW'(int'(dwv) - 60 - 30 * k);
    end
  endtask

  initial begin
    int lat;
    total = 0; bad = 0;
    rst_n = 0;
    wv = '0; dwv = '0;
    for (int k = 0; k < NT; k++) begin tv[k] = '0; dtv[k] = '0; end
    clear_inputs();
    bus.wave_in = '0; bus.dwave_in = '0; bus.tmpl_in = '0; bus.dtmpl_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.result_valid), 32'd0);
    check("reset_score", 32'(bus.result_score), 32'd0);

    // 16 exact matches on class 0
    put(1, 0, 0);
    for (int i = 0; i < 16; i++) begin set_match(0, i); put(0, 1, i == 15); end
    wait_result(0, lat);
    check("t1_type", 32'(exp_type), 32'd0);
    check("t1_score", 32'(exp_score), 32'd4128);
`ifdef CLASSIFIER_MARGIN_EN
    check("t1_margin", 32'(exp_margin), 32'd96);
`endif

    // 3000 hits on class 2: saturation high and low
    put(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin set_match(2, i); put(0, 1, i == 2999); end
    wait_result(1, lat);
    check("t2_type", 32'(exp_type), 32'd2);
    check("t2_score", 32'(exp_score), 32'd8190);
    check("t2_raw_lo", 32'(raw_m[0] + der_m[3]), 32'd0);

    // identical winning templates on classes 1 and 3
    put(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      set_match(1, i); tv[3] = tv[1]; dtv[3] = dtv[1];
      put(0, 1, i == 9);
    end
    wait_result(0, lat);
    check("t3_type", 32'(exp_type), 32'd1);
    check("t3_margin", 32'(exp_margin), 32'd0);

    // threshold boundaries in a single-sample frame
    wv = 8'd0; dwv = 8'd100;
    tv[0] = 8'd10;  tv[1] = 8'd11;  tv[2] = 8'd255; tv[3] = 8'd0;
    dtv[0] = 8'd102; dtv[1] = 8'd103; dtv[2] = 8'd100; dtv[3] = 8'd200;
    put(1, 0, 0);
    put(0, 1, 1);
    wait_result(0, lat);
    check("t4_type", 32'(exp_type), 32'd0);
    check("t4_score", 32'(exp_score), 32'd4098);
`ifdef CLASSIFIER_MARGIN_EN
    check("t4_margin", 32'(exp_margin), 32'd3);
`endif

    // restart mid-frame (with a discarded same-cycle sample), then 8 matches on class 3
    put(1, 0, 0);
    for (int i = 0; i < 5; i++) begin set_match(i % NT, i); put(0, 1, 0); end
    set_match(0, 7);
    put(1, 1, 1);
    for (int i = 0; i < 8; i++) begin set_match(3, i); put(0, 1, i == 7); end
    wait_result(0, lat);
    check("t5_type", 32'(exp_type), 32'd3);
    check("t5_score", 32'(exp_score), 32'd4112);
    check("t5_latency", 32'(lat), 32'(NT + 1));

    // reset while comparing
    put(1, 0, 0);
    for (int i = 0; i < 6; i++) begin set_match(2, i); put(0, 1, i == 5); end
    @(posedge clk);
    @(negedge clk) begin clear_inputs(); rst_n = 0; end
    @(negedge clk) rst_n = 1;
    repeat (NT + 3) @(posedge clk);
    #1;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_type", 32'(bus.result_type), 32'd0);
    check("t6_score", 32'(bus.result_score), 32'd0);
    put(1, 0, 0);
    for (int i = 0; i < 12; i++) begin set_match(1, i); put(0, 1, i == 11); end
    wait_result(0, lat);
    check("t6_next_type", 32'(exp_type), 32'd1);
    check("t6_next_score", 32'(exp_score), 32'd4120);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int len;
      len = int'($urandom_range(1, 30));
      put(1, 0, 0);
      for (int i = 0; i < len; i++) begin
        int c;
        for (int k = 0; k < NT; k++) begin
          tv[k]  = DW'($urandom_range(0, 255));
          dtv[k] = DW'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 4) == 0) begin tv[NT-1] = tv[0]; dtv[NT-1] = dtv[0]; end
        c   = int'($urandom_range(0, NT - 1));
        wv  = near(tv[c], 12);
        dwv = near(dtv[c], 3);
        if ($urandom_range(0, 3) == 0) put(0, 0, 1'($urandom_range(0, 1)));
        if (i == len - 1 && $urandom_range(0, 4) == 0) put(1, 1, 1);
        put(($urandom_range(0, 24) == 0) && (i != len - 1), 1, i == len - 1);
      end
      wait_result(1'(f % 2), lat);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
